// File: rtl/jtopl_wrqueue.sv
// Host write queue for the jtopl CPU port: buffers {addr,data} writes and replays them
// onto din/addr/cs_n/wr_n with OPL recovery gaps counted in cen cycles.
module jtopl_wrqueue #(
   parameter int DEPTH     = 16,
   parameter int ADDR_WAIT = 12,
   parameter int DATA_WAIT = 84
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cen,
   input  logic       wr_en,
   input  logic       wr_addr,
   input  logic [7:0] wr_data,
   output logic       full,
   output logic       empty,
   output logic       busy,
   output logic       ovf,
   output logic [7:0] opl_din,
   output logic       opl_addr,
   output logic       opl_cs_n,
   output logic       opl_wr_n
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STROBE = 2'd1,
      S_WAIT   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [8:0]  mem_q [DEPTH];
   logic [AW:0] wptr_q, wptr_d;
   logic [AW:0] rptr_q, rptr_d;
   logic        ovf_q, ovf_d;
   logic [7:0]  din_q, din_d;
   logic        addr_q, addr_d;
   logic        strb_n_q, strb_n_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        push, pop;
   logic [8:0]  head;

   // full is taken from the registered pointers, so a push while full is rejected even if a pop lands on the same edge
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty = (wptr_q == rptr_q);
   assign busy  = !empty || (state_q != S_IDLE);
   assign push  = wr_en && !full;
   assign head  = mem_q[rptr_q[AW-1:0]];

   assign opl_din  = din_q;
   assign opl_addr = addr_q;
   assign opl_cs_n = strb_n_q;
   assign opl_wr_n = strb_n_q;
   assign ovf      = ovf_q;

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q[AW-1:0]] <= {wr_addr, wr_data};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (!empty) state_d = S_STROBE;
         S_STROBE: if (cen) state_d = S_WAIT;
         S_WAIT:   if (cen && cnt_q <= 8'd1) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pop      = 1'b0;
      din_d    = din_q;
      addr_d   = addr_q;
      strb_n_d = strb_n_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop      = 1'b1;
               din_d    = head[7:0];
               addr_d   = head[8];
               strb_n_d = 1'b0;
            end
         end
         S_STROBE: begin
            if (cen) begin
               strb_n_d = 1'b1;
               cnt_d    = addr_q ? 8'(DATA_WAIT) : 8'(ADDR_WAIT);
            end
         end
         S_WAIT: begin
            if (cen) cnt_d = cnt_q - 8'd1;
         end
         default: strb_n_d = 1'b1;
      endcase
   end

   always_comb begin
      wptr_d = push ? wptr_q + (AW+1)'(1) : wptr_q;
      rptr_d = pop  ? rptr_q + (AW+1)'(1) : rptr_q;
      ovf_d  = ovf_q || (wr_en && full);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         ovf_q    <= 1'b0;
         din_q    <= 8'd0;
         addr_q   <= 1'b0;
         strb_n_q <= 1'b1;
         cnt_q    <= 8'd0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         ovf_q    <= ovf_d;
         din_q    <= din_d;
         addr_q   <= addr_d;
         strb_n_q <= strb_n_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule
